// File: rtl/oven_clock_setter.sv
`default_nettype none
// ============================================================================
// Module      : oven_clock_setter
// Description : Front-panel time-set controller for the oven clock. Debounces
//               the MODE and INC buttons, walks RUN / SET_HOUR / SET_MIN,
//               edits a shadow BCD hh:mm, and issues a one-cycle load pulse
//               to the time-of-day counter. Drives per-field blink masks.
// Revision    : 1.0 - initial release
// ============================================================================
module oven_clock_setter #(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int BLINK_HALF    = 12_500_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min2,
    input  logic [3:0] cur_hour1,
    input  logic [3:0] cur_hour2,
    output logic [3:0] set_min1,
    output logic [3:0] set_min2,
    output logic [3:0] set_hour1,
    output logic [3:0] set_hour2,
    output logic       load,
    output logic       setting,
    output logic       blank_hours,
    output logic       blank_mins,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W   = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]    c_db_last    = DB_W'(DB_CYCLES - 1);
    localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_HALF - 1);
    localparam logic [HOLD_W-1:0]  c_hold_last  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  c_hold_done  = HOLD_W'(HOLD_CYCLES);
    localparam logic [REP_W-1:0]   c_rep_last   = REP_W'(REPEAT_CYCLES - 1);

    // Button index 0 is MODE, index 1 is INC.
    logic [1:0]            w_raw_btn;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            stable_q, stable_d;
    logic [1:0]            press_q, press_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;

    state_t                state_q, state_d;
    logic                  load_q, load_d;
    logic                  setting_q, setting_d;
    logic                  blank_hours_q, blank_hours_d;
    logic                  blank_mins_q, blank_mins_d;
    logic [3:0]            set_min1_q, set_min1_d;
    logic [3:0]            set_min2_q, set_min2_d;
    logic [3:0]            set_hour1_q, set_hour1_d;
    logic [3:0]            set_hour2_q, set_hour2_d;

    logic                  w_mode_press;
    logic                  w_inc_press;
    logic                  w_rep_tick;
    logic                  w_incr_apply;
    logic [7:0]            w_hour_next;
    logic [7:0]            w_min_next;

    // Next BCD hour {tens, ones}; anything outside 00..22 lands on 00.
    function automatic logic [7:0] next_hour(input logic [3:0] tens,
                                             input logic [3:0] ones);
        logic [7:0] r;
        if (tens > 4'd2 || ones > 4'd9 || (tens == 4'd2 && ones >= 4'd3)) begin
            r = 8'h00;
        end else if (ones == 4'd9) begin
            r = {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
        return r;
    endfunction

    // Next BCD minute {tens, ones}; 59 and invalid values land on 00.
    function automatic logic [7:0] next_min(input logic [3:0] tens,
                                            input logic [3:0] ones);
        logic [7:0] r;
        if (tens > 4'd5 || ones > 4'd9 || (tens == 4'd5 && ones == 4'd9)) begin
            r = 8'h00;
        end else if (ones == 4'd9) begin
            r = {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
        return r;
    endfunction

    assign w_raw_btn    = {btn_inc, btn_mode};
    assign w_mode_press = press_q[0];
    assign w_inc_press  = press_q[1];
    assign w_hour_next  = next_hour(set_hour2_q, set_hour1_q);
    assign w_min_next   = next_min(set_min2_q, set_min1_q);

    // An increment only lands in a SET state, and a MODE press in the same
    // cycle takes priority over it.
    assign w_incr_apply = (w_inc_press || w_rep_tick) && !w_mode_press &&
                          (state_q != ST_RUN);

    // Synchronise both buttons, debounce them and form rising-edge presses.
    always_comb begin
        sync1_d  = w_raw_btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = 2'b00;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == c_db_last) begin
                    stable_d[i] = sync2_q[i];
                    press_d[i]  = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat: hold delay, then a tick every repeat period while INC stays
    // down in a SET state; any MODE press (always a state change) restarts it.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        w_rep_tick = 1'b0;
        if (state_q == ST_RUN || !stable_q[1] || w_mode_press) begin
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
        end else if (hold_cnt_q != c_hold_done) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_q == c_hold_last) begin
                w_rep_tick = 1'b1;
            end
        end else if (rep_cnt_q == c_rep_last) begin
            rep_cnt_d  = '0;
            w_rep_tick = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    // Mode state machine, snapshot of the live time and field edits.
    always_comb begin
        state_d     = state_q;
        load_d      = 1'b0;
        set_min1_d  = set_min1_q;
        set_min2_d  = set_min2_q;
        set_hour1_d = set_hour1_q;
        set_hour2_d = set_hour2_q;
        case (state_q)
            ST_RUN: begin
                if (w_mode_press) begin
                    state_d     = ST_SET_HOUR;
                    set_min1_d  = cur_min1;
                    set_min2_d  = cur_min2;
                    set_hour1_d = cur_hour1;
                    set_hour2_d = cur_hour2;
                end
            end
            ST_SET_HOUR: begin
                if (w_mode_press) begin
                    state_d = ST_SET_MIN;
                end else if (w_incr_apply) begin
                    set_hour2_d = w_hour_next[7:4];
                    set_hour1_d = w_hour_next[3:0];
                end
            end
            ST_SET_MIN: begin
                if (w_mode_press) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (w_incr_apply) begin
                    set_min2_d = w_min_next[7:4];
                    set_min1_d = w_min_next[3:0];
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        setting_d = (state_d != ST_RUN);
    end

    // Blink phase restarts visible on every state entry and every edit.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (w_mode_press || w_incr_apply || state_q == ST_RUN) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
        blank_hours_d = (state_d == ST_SET_HOUR) && phase_d;
        blank_mins_d  = (state_d == ST_SET_MIN) && phase_d;
    end

    // Button synchroniser and debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Control, timer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            load_q        <= 1'b0;
            setting_q     <= 1'b0;
            blank_hours_q <= 1'b0;
            blank_mins_q  <= 1'b0;
            set_min1_q    <= '0;
            set_min2_q    <= '0;
            set_hour1_q   <= '0;
            set_hour2_q   <= '0;
            hold_cnt_q    <= '0;
            rep_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_q        <= load_d;
            setting_q     <= setting_d;
            blank_hours_q <= blank_hours_d;
            blank_mins_q  <= blank_mins_d;
            set_min1_q    <= set_min1_d;
            set_min2_q    <= set_min2_d;
            set_hour1_q   <= set_hour1_d;
            set_hour2_q   <= set_hour2_d;
            hold_cnt_q    <= hold_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
        end
    end

    assign state       = state_q;
    assign load        = load_q;
    assign setting     = setting_q;
    assign blank_hours = blank_hours_q;
    assign blank_mins  = blank_mins_q;
    assign set_min1    = set_min1_q;
    assign set_min2    = set_min2_q;
    assign set_hour1   = set_hour1_q;
    assign set_hour2   = set_hour2_q;

endmodule
`default_nettype wire
